cpu_debug_host_jtag_scanner: RTL and testbench

//  Host-side initiator for the Nios II debug slave's virtual-JTAG interface. Turns one
//  {IR, DR} command into a full scan: UIR, CDR, DR_WIDTH-bit SDR shift, UDR, then RTI idle.

---
 rtl/cpu_debug_host_jtag_scanner.sv | 147 ++++++++++++++
 tb/tb_cpu_debug_host_jtag_scanner.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_debug_host_jtag_scanner.sv
// Host-side virtual-JTAG scan engine for the Nios II debug slave.
// Each command runs one full scan: UIR, CDR, SDR shift, UDR and an RTI idle. The TDO bits captured during SDR are returned as the response.
module cpu_debug_host_jtag_scanner #(
    parameter int DR_WIDTH = 38,
    parameter int IR_WIDTH = 2,
    parameter int CLK_DIV  = 2,
    parameter int RTI_TCKS = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_data,
    output logic                vj_tck,
    output logic                vj_tdi,
    input  logic                vj_tdo,
    output logic [IR_WIDTH-1:0] vj_ir_in,
    output logic                vj_uir,
    output logic                vj_cdr,
    output logic                vj_sdr,
    output logic                vj_udr,
    output logic                vj_rti
);

    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_TOP = (DR_WIDTH > RTI_TCKS) ? DR_WIDTH : RTI_TCKS;
    localparam int CNT_W   = $clog2(CNT_TOP + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] SDR_LAST = CNT_W'(DR_WIDTH - 1);
    localparam logic [CNT_W-1:0] RTI_LAST = CNT_W'((RTI_TCKS > 0) ? RTI_TCKS - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CNT_TOP);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UIR,
        ST_CDR,
        ST_SDR,
        ST_UDR,
        ST_RTI,
        ST_RSP
    } state_t;

    state_t              state_q, state_d;
    logic                tck_q;
    logic [DIV_W-1:0]    div_cnt_q;
    logic [CNT_W-1:0]    tck_cnt_q;
    logic [IR_WIDTH-1:0] ir_q;
    logic [DR_WIDTH-1:0] data_sh_q;
    logic [DR_WIDTH-1:0] cap_q;
    logic [DR_WIDTH-1:0] rsp_data_q;

    logic scanning;
    logic phase_end;
    logic tck_rise;
    logic period_end;
    logic accept;

    assign scanning   = (state_q != ST_IDLE) && (state_q != ST_RSP);
    assign phase_end  = scanning && (div_cnt_q == DIV_LAST);
    assign tck_rise   = phase_end && !tck_q;
    // A phase ending with tck high closes a tck period; the next low phase starts on this edge.
    assign period_end = phase_end && tck_q;
    assign accept     = (state_q == ST_IDLE) && cmd_valid;

    // NOTE: every output of a combinational block gets a default first so that no path infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (cmd_valid) state_d = ST_UIR;
            ST_UIR:  if (period_end) state_d = ST_CDR;
            ST_CDR:  if (period_end) state_d = ST_SDR;
            ST_SDR:  if (period_end && (tck_cnt_q == SDR_LAST)) state_d = ST_UDR;
            ST_UDR:  if (period_end) state_d = (RTI_TCKS > 0) ? ST_RTI : ST_RSP;
            ST_RTI:  if (period_end && (tck_cnt_q == RTI_LAST)) state_d = ST_RSP;
            ST_RSP:  if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == ST_IDLE);
        rsp_valid = (state_q == ST_RSP);
        rsp_data  = rsp_data_q;
        vj_tck    = tck_q;
        vj_ir_in  = ir_q;
        vj_uir    = (state_q == ST_UIR);
        vj_cdr    = (state_q == ST_CDR);
        vj_sdr    = (state_q == ST_SDR);
        vj_udr    = (state_q == ST_UDR);
        vj_rti    = (state_q == ST_IDLE) || (state_q == ST_RTI) || (state_q == ST_RSP);
        vj_tdi    = (state_q == ST_SDR) && data_sh_q[0];
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            tck_q      <= 1'b0;
            div_cnt_q  <= '0;
            tck_cnt_q  <= '0;
            ir_q       <= '0;
            data_sh_q  <= '0;
            cap_q      <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                tck_q     <= 1'b0;
                div_cnt_q <= '0;
                tck_cnt_q <= '0;
                ir_q      <= cmd_ir;
                data_sh_q <= cmd_data;
                cap_q     <= '0;
            end else if (scanning) begin
                if (phase_end) begin
                    div_cnt_q <= '0;
                    tck_q     <= !tck_q;
                end else begin
                    div_cnt_q <= div_cnt_q + 1'b1;
                end
                // Slave's rising edge: shifting in from the top lands the first sample in bit 0.
                if (tck_rise && (state_q == ST_SDR)) begin
                    cap_q <= {vj_tdo, cap_q[DR_WIDTH-1:1]};
                end
                if (period_end) begin
                    if (state_d != state_q) begin
                        tck_cnt_q <= '0;
                    end else if (tck_cnt_q != CNT_SAT) begin
                        tck_cnt_q <= tck_cnt_q + 1'b1;
                    end
                    if (state_q == ST_SDR) begin
                        data_sh_q <= {1'b0, data_sh_q[DR_WIDTH-1:1]};
                    end
                end
            end
            if ((state_d == ST_RSP) && (state_q != ST_RSP)) begin
                rsp_data_q <= cap_q;
            end
        end
    end

endmodule

// File: tb/tb_cpu_debug_host_jtag_scanner.sv
// Self-checking bench for cpu_debug_host_jtag_scanner.
// A behavioural slave shift-register model checks each scan's loopback, its timing, backpressure, IR sequencing, a mid-scan reset and the CLK_DIV=1 case.
module tb_cpu_debug_host_jtag_scanner;

    localparam int DRW = 38;
    localparam int IRW = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic           cmd_valid0 = 1'b0, cmd_ready0, rsp_valid0, rsp_ready0 = 1'b0;
    logic [IRW-1:0] cmd_ir0 = '0, ir_in0;
    logic [DRW-1:0] cmd_data0 = '0, rsp_data0;
    logic           tck0, tdi0, tdo0, uir0, cdr0, sdr0, udr0, rti0;

    logic           cmd_valid1 = 1'b0, cmd_ready1, rsp_valid1, rsp_ready1 = 1'b0;
    logic [IRW-1:0] cmd_ir1 = '0, ir_in1;
    logic [DRW-1:0] cmd_data1 = '0, rsp_data1;
    logic           tck1, tdi1, tdo1 = 1'b0, uir1, cdr1, sdr1, udr1, rti1;

    cpu_debug_host_jtag_scanner #(.DR_WIDTH(DRW), .IR_WIDTH(IRW), .CLK_DIV(2), .RTI_TCKS(2)) dut0 (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0), .cmd_ir(cmd_ir0), .cmd_data(cmd_data0),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_data(rsp_data0),
        .vj_tck(tck0), .vj_tdi(tdi0), .vj_tdo(tdo0), .vj_ir_in(ir_in0),
        .vj_uir(uir0), .vj_cdr(cdr0), .vj_sdr(sdr0), .vj_udr(udr0), .vj_rti(rti0)
    );

    cpu_debug_host_jtag_scanner #(.DR_WIDTH(DRW), .IR_WIDTH(IRW), .CLK_DIV(1), .RTI_TCKS(2)) dut1 (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1), .cmd_ir(cmd_ir1), .cmd_data(cmd_data1),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_data(rsp_data1),
        .vj_tck(tck1), .vj_tdi(tdi1), .vj_tdo(tdo1), .vj_ir_in(ir_in1),
        .vj_uir(uir1), .vj_cdr(cdr1), .vj_sdr(sdr1), .vj_udr(udr1), .vj_rti(rti1)
    );

    // Slave model for dut0: an sr register that shifts on each rising tck while in SDR.
    logic [DRW-1:0] sr0, preload0 = '0;
    logic           load0 = 1'b0, tck0_prev = 1'b0;
    int             uir_rises = 0, cdr_rises = 0, sdr_rises = 0, udr_rises = 0;
    assign tdo0 = sr0[0];

    always @(posedge clk) begin
        if (load0) sr0 <= preload0;
        else if (tck0 && !tck0_prev && sdr0) sr0 <= {tdi0, sr0[DRW-1:1]};
        if (tck0 && !tck0_prev) begin
            if (uir0) uir_rises <= uir_rises + 1;
            if (cdr0) cdr_rises <= cdr_rises + 1;
            if (sdr0) sdr_rises <= sdr_rises + 1;
            if (udr0) udr_rises <= udr_rises + 1;
        end
        tck0_prev <= tck0;
    end

    // Slave model for dut1: only its shift-in side is observed, tdo1 is tied low.
    logic [DRW-1:0] sr1, preload1 = '0;
    logic           load1 = 1'b0, tck1_prev = 1'b0;

    always @(posedge clk) begin
        if (load1) sr1 <= preload1;
        else if (tck1 && !tck1_prev && sdr1) sr1 <= {tdi1, sr1[DRW-1:1]};
        tck1_prev <= tck1;
    end

    // Protocol watchers: IR may change only in UIR and must match the command while shifting.
    logic [IRW-1:0] exp_ir = '0, ir0_prev = '0;
    int             ir_bad = 0, onehot_bad = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if ((ir_in0 !== ir0_prev) && !uir0) ir_bad++;
            if (tck0 && sdr0 && (ir_in0 !== exp_ir)) ir_bad++;
            if ($countones({uir0, cdr0, sdr0, udr0, rti0}) != 1) onehot_bad++;
        end
        ir0_prev = ir_in0;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete scan on dut0; rsp_ready stays low for bp cycles after rsp_valid.
    task automatic scan0(input logic [IRW-1:0] ir, input logic [DRW-1:0] data,
                         input logic [DRW-1:0] pre, input int bp,
                         output logic [DRW-1:0] rsp, output int lat, output int hold_bad);
        @(negedge clk);
        preload0 = pre;
        load0    = 1'b1;
        @(negedge clk);
        load0      = 1'b0;
        exp_ir     = ir;
        cmd_ir0    = ir;
        cmd_data0  = data;
        cmd_valid0 = 1'b1;
        rsp_ready0 = 1'b0;
        @(posedge clk);
        #1;
        cmd_valid0 = 1'b0;
        cmd_data0  = ~data;
        cmd_ir0    = ~ir;
        lat = 0;
        while (lat < 400) begin
            @(posedge clk);
            lat++;
            #1;
            if (rsp_valid0) break;
        end
        rsp = rsp_data0;
        hold_bad = 0;
        cmd_valid0 = (bp > 0);
        for (int i = 0; i < bp; i++) begin
            @(posedge clk);
            #1;
            if (!rsp_valid0 || (rsp_data0 !== rsp) || cmd_ready0 || tck0) hold_bad++;
        end
        cmd_valid0 = 1'b0;
        rsp_ready0 = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready0 = 1'b0;
    endtask

    localparam int LAT0 = 2 * 2 * (DRW + 3 + 2);
    localparam int LAT1 = 2 * 1 * (DRW + 3 + 2);

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DRW-1:0] rsp, data, pre;
        logic [IRW-1:0] ir;
        logic [3:0]     pat;
        int             lat, hb, u0, c0, s0, d0, waited, seen;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tck", tck0, 1'b0);
        check("rst_tdi", tdi0, 1'b0);
        check("rst_ir_in", ir_in0, '0);
        check("rst_states", {uir0, cdr0, sdr0, udr0}, 4'b0000);
        check("rst_rti", rti0, 1'b1);
        check("rst_rsp_valid", rsp_valid0, 1'b0);
        check("rst_rsp_data", rsp_data0, '0);
        check("rst_cmd_ready", cmd_ready0, 1'b1);
        reset = 1'b0;

        // Loopback with timing and backpressure
        u0 = uir_rises; c0 = cdr_rises; s0 = sdr_rises; d0 = udr_rises;
        scan0(2'b01, 38'h15_A5A5_A5A5, 38'h2A_5A5A_5A5A, 20, rsp, lat, hb);
        check("loop_rsp", rsp, 38'h2A_5A5A_5A5A);
        check("loop_sr", sr0, 38'h15_A5A5_A5A5);
        check("loop_latency", lat, LAT0);
        check("loop_uir_edges", uir_rises - u0, 1);
        check("loop_cdr_edges", cdr_rises - c0, 1);
        check("loop_sdr_edges", sdr_rises - s0, DRW);
        check("loop_udr_edges", udr_rises - d0, 1);
        check("bp_hold", hb, 0);
        check("bp_rsp_dropped", rsp_valid0, 1'b0);
        check("bp_cmd_ready", cmd_ready0, 1'b1);

        // IR sequencing
        data = {$urandom(), $urandom()};
        pre  = {$urandom(), $urandom()};
        scan0(2'b11, data, pre, 0, rsp, lat, hb);
        check("ir3_rsp", rsp, pre);
        check("ir3_sr", sr0, data);
        check("ir3_ir_in", ir_in0, 2'b11);
        data = {$urandom(), $urandom()};
        pre  = {$urandom(), $urandom()};
        scan0(2'b00, data, pre, 0, rsp, lat, hb);
        check("ir0_rsp", rsp, pre);
        check("ir0_ir_in", ir_in0, 2'b00);

        // Randomized scans
        for (int n = 0; n < 4; n++) begin
            ir   = IRW'($urandom_range(0, 3));
            data = {$urandom(), $urandom()};
            pre  = {$urandom(), $urandom()};
            scan0(ir, data, pre, int'($urandom_range(0, 5)), rsp, lat, hb);
            check("rand_rsp", rsp, pre);
            check("rand_sr", sr0, data);
            check("rand_latency", lat, LAT0);
            check("rand_hold", hb, 0);
        end

        // Mid-SDR reset aborts without a response
        @(negedge clk);
        s0 = sdr_rises;
        exp_ir = 2'b10;
        cmd_ir0 = 2'b10;
        cmd_data0 = {$urandom(), $urandom()};
        cmd_valid0 = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid0 = 1'b0;
        waited = 0;
        while ((sdr_rises - s0 < 10) && (waited < 400)) begin
            @(negedge clk);
            waited++;
        end
        check("abort_reached_shift10", sdr_rises - s0, 10);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_tck", tck0, 1'b0);
        check("abort_sdr", sdr0, 1'b0);
        check("abort_rti", rti0, 1'b1);
        check("abort_rsp_valid", rsp_valid0, 1'b0);
        check("abort_cmd_ready", cmd_ready0, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (200) begin
            @(negedge clk);
            if (rsp_valid0 || tck0) seen++;
        end
        check("abort_quiet", seen, 0);

        data = {$urandom(), $urandom()};
        pre  = {$urandom(), $urandom()};
        scan0(2'b01, data, pre, 0, rsp, lat, hb);
        check("recover_rsp", rsp, pre);
        check("recover_latency", lat, LAT0);

        // CLK_DIV=1 boundary on dut1
        @(negedge clk);
        preload1 = '0;
        load1 = 1'b1;
        @(negedge clk);
        load1 = 1'b0;
        cmd_ir1 = 2'b01;
        cmd_data1 = '1;
        cmd_valid1 = 1'b1;
        @(posedge clk);
        #1;
        pat[0] = tck1;
        cmd_valid1 = 1'b0;
        cmd_data1 = '0;
        for (int i = 1; i < 4; i++) begin
            @(posedge clk);
            #1;
            pat[i] = tck1;
        end
        lat = 3;
        while ((lat < 400) && !rsp_valid1) begin
            @(posedge clk);
            lat++;
            #1;
        end
        check("div1_tck_pattern", pat, 4'b1010);
        check("div1_latency", lat, LAT1);
        check("div1_rsp", rsp_data1, '0);
        check("div1_sr", sr1, {DRW{1'b1}});
        rsp_ready1 = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready1 = 1'b0;
        check("div1_cmd_ready", cmd_ready1, 1'b1);

        check("ir_only_in_uir", ir_bad, 0);
        check("one_state_high", onehot_bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
